vram_rgb_ctrl: RTL and testbench

VRAM_RGB_CTRL -- requirements
Module: vram_rgb_ctrl

---
 rtl/vram_rgb_ctrl_if.sv | 39 +++
 rtl/vram_rgb_ctrl.sv | 158 +++++++++++++++
 tb/tb_vram_rgb_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_rgb_ctrl_if.sv
// -----------------------------------------------------------------------------
// vram_rgb_ctrl_if
// Bundles the three VRAM ports of vram_rgb_ctrl:
//   read  : rd_en, rd_addr -> rd_data, rd_valid      (display scanner)
//   write : wr_valid, wr_addr, wr_data, wr_mask -> wr_ready
//   fill  : clr_start, clr_color -> clr_busy, clr_done
// master = requester side (scanner / CPU / bench), slave = vram_rgb_ctrl.
// -----------------------------------------------------------------------------
interface vram_rgb_ctrl_if #(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned BITS     = 1,
    parameter int unsigned ADDR_W   = 14
);
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic [CHANNELS*BITS-1:0] rd_data;
    logic                     rd_valid;

    logic                     wr_valid;
    logic                     wr_ready;
    logic [ADDR_W-1:0]        wr_addr;
    logic [CHANNELS*BITS-1:0] wr_data;
    logic [CHANNELS-1:0]      wr_mask;

    logic                     clr_start;
    logic [CHANNELS*BITS-1:0] clr_color;
    logic                     clr_busy;
    logic                     clr_done;

    modport master (
        output rd_en, rd_addr, wr_valid, wr_addr, wr_data, wr_mask, clr_start, clr_color,
        input  rd_data, rd_valid, wr_ready, clr_busy, clr_done
    );

    modport slave (
        input  rd_en, rd_addr, wr_valid, wr_addr, wr_data, wr_mask, clr_start, clr_color,
        output rd_data, rd_valid, wr_ready, clr_busy, clr_done
    );
endinterface

// File: rtl/vram_rgb_ctrl.sv
// -----------------------------------------------------------------------------
// vram_rgb_ctrl
// Pixel frame buffer (DEPTH x CHANNELS*BITS) with:
//   - a 1-cycle-latency read port that is served every cycle, read-first on
//     address collisions, returning 0 for addresses >= DEPTH;
//   - a valid/ready masked write port, open only while the fill FSM is idle;
//   - a full-frame fill engine (IDLE -> FILL -> DONE) writing one pixel/cycle.
// Ports:
//   clk   : rising-edge clock for logic and memory
//   reset : asynchronous active-high reset (control and output registers only;
//           memory contents survive reset)
//   bus   : vram_rgb_ctrl_if.slave (read, write and fill channels)
// -----------------------------------------------------------------------------
module vram_rgb_ctrl #(
    parameter int unsigned              CHANNELS   = 3,
    parameter int unsigned              BITS       = 1,
    parameter int unsigned              ADDR_W     = 14,
    parameter int unsigned              DEPTH      = 12288,
    parameter logic [CHANNELS*BITS-1:0] INIT_PIXEL = '1
) (
    input logic            clk,
    input logic            reset,
    vram_rgb_ctrl_if.slave bus
);
    localparam int unsigned PW      = CHANNELS * BITS;
    localparam int unsigned AW1     = ADDR_W + 1;
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   DepthW   = AW1'(DEPTH);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

    // Power-up image; never touched by reset.
    logic [PW-1:0] mem [DEPTH] = '{default: INIT_PIXEL};

    state_e            state_q,    state_d;
    logic [ADDR_W-1:0] cnt_q,      cnt_d;
    logic [PW-1:0]     color_q,    color_d;
    logic [PW-1:0]     rd_data_q,  rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              wr_ready_q, wr_ready_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;

    logic              rd_in_range;
    logic              wr_in_range;
    logic              wr_fire;
    logic [PW-1:0]     bit_mask;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [PW-1:0]     mem_wdata;

    assign rd_in_range = {1'b0, bus.rd_addr} < DepthW;
    assign wr_in_range = {1'b0, bus.wr_addr} < DepthW;
    assign wr_fire     = bus.wr_valid & wr_ready_q;

    // Fill FSM next state; status outputs are derived from the next state so
    // the registered copies line up with the state they describe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        unique case (state_q)
            StIdle: begin
                if (bus.clr_start) begin
                    state_d = StFill;
                    cnt_d   = '0;
                    color_d = bus.clr_color;
                end
            end
            StFill: begin
                if (cnt_q == LastAddr) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        wr_ready_d = (state_d == StIdle);
        busy_d     = (state_d != StIdle);
        done_d     = (state_d == StDone);
    end

    // Read port: old memory contents are sampled, so a same-cycle write to the
    // same address is not yet visible (read-first).
    always_comb begin
        rd_valid_d = bus.rd_en;
        rd_data_d  = rd_data_q;
        if (bus.rd_en) begin
            rd_data_d = rd_in_range ? mem[bus.rd_addr] : '0;
        end
    end

    // Expand per-channel mask to per-bit mask.
    always_comb begin
        bit_mask = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            bit_mask[c*BITS +: BITS] = {BITS{bus.wr_mask[c]}};
        end
    end

    // Single memory write port shared by the fill engine and the write
    // channel; they never overlap because wr_ready is low outside IDLE.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdata = (mem[bus.wr_addr] & ~bit_mask) | (bus.wr_data & bit_mask);
        if (state_q == StFill) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = color_q;
        end else if (wr_fire && wr_in_range) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            color_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            color_q    <= color_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_ready_q <= wr_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.wr_ready = wr_ready_q;
    assign bus.clr_busy = busy_q;
    assign bus.clr_done = done_q;

endmodule

// File: tb/tb_vram_rgb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vram_rgb_ctrl
// Self-checking bench for vram_rgb_ctrl. Reads push the expected pixel (from a
// bench-side memory model, pre-write) into a queue; a negedge monitor pops and
// compares whenever rd_valid is high. Scenario tasks add inline checks.
// -----------------------------------------------------------------------------
module tb_vram_rgb_ctrl;
    localparam int unsigned CHANNELS = 3;
    localparam int unsigned BITS     = 1;
    localparam int unsigned ADDR_W   = 14;
    localparam int          DEPTH    = 12288;

    logic clk = 1'b0;
    logic reset;

    vram_rgb_ctrl_if #(.CHANNELS(CHANNELS), .BITS(BITS), .ADDR_W(ADDR_W)) bus ();

    vram_rgb_ctrl #(
        .CHANNELS  (CHANNELS),
        .BITS      (BITS),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .INIT_PIXEL(3'b111)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [2:0] exp_q [$];
    logic [2:0] model [DEPTH];
    logic [2:0] mon_exp;

    function automatic logic [2:0] model_read(input logic [13:0] a);
        if (int'(a) >= DEPTH) return 3'b000;
        return model[a];
    endfunction

    // Advance one clock: record expected read result and apply the write to
    // the model as the DUT sees them at this edge, then sample at edge + 1.
    task automatic tick();
        if (bus.rd_en) exp_q.push_back(model_read(bus.rd_addr));
        if (bus.wr_valid && int'(bus.wr_addr) < DEPTH) begin
            for (int c = 0; c < 3; c++) begin
                if (bus.wr_mask[c]) model[bus.wr_addr][c] = bus.wr_data[c];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [13:0] a);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic do_write(input logic [13:0] a, input logic [2:0] d, input logic [2:0] m);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        bus.wr_mask  = m;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.rd_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_extra: rd_valid=1 with no read pending, rd_data=%b", bus.rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.rd_data !== mon_exp) begin
                    bad++;
                    $display("FAIL rd_data: got %b want %b", bus.rd_data, mon_exp);
                end
            end
        end
    end

    task automatic test_reset();
        reset         = 1'b1;
        bus.rd_en     = 1'b1;
        bus.rd_addr   = 14'd0;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.wr_mask   = '0;
        bus.clr_start = 1'b0;
        bus.clr_color = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.rd_data !== 3'b000) begin bad++; $display("FAIL rst_rd_data: got %b want 000", bus.rd_data); end
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid: got %b want 0", bus.rd_valid); end
        total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL rst_wr_ready: got %b want 0", bus.wr_ready); end
        total++; if (bus.clr_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.clr_busy); end
        total++; if (bus.clr_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", bus.clr_done); end
        bus.rd_en = 1'b0;
        reset     = 1'b0;
        #1;
        total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge: got %b want 0", bus.wr_ready); end
        @(posedge clk);
        #1;
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL ready_after_edge: got %b want 1", bus.wr_ready); end
    endtask

    task automatic test_powerup();
        logic [13:0] a;
        for (int i = 0; i < 3; i++) begin
            a = (i == 0) ? 14'd0 : (i == 1) ? 14'd5000 : 14'd12287;
            do_read(a);
            total++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== 3'b111) begin
                bad++;
                $display("FAIL powerup_rd[%0d]: got valid=%b data=%b want valid=1 data=111", a, bus.rd_valid, bus.rd_data);
            end
        end
        tick();
        total++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== 3'b111) begin
            bad++;
            $display("FAIL rd_hold: got valid=%b data=%b want valid=0 data=111", bus.rd_valid, bus.rd_data);
        end
    endtask

    task automatic test_write_mask();
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL wm_ready: got %b want 1", bus.wr_ready); end
        do_write(14'd100, 3'b010, 3'b111);
        do_read(14'd100);
        total++; if (bus.rd_data !== 3'b010) begin bad++; $display("FAIL wm_full: got %b want 010", bus.rd_data); end
        do_write(14'd100, 3'b101, 3'b001);
        do_read(14'd100);
        total++; if (bus.rd_data !== 3'b011) begin bad++; $display("FAIL wm_ch0: got %b want 011", bus.rd_data); end
        do_write(14'd100, 3'b100, 3'b100);
        do_read(14'd100);
        total++; if (bus.rd_data !== 3'b111) begin bad++; $display("FAIL wm_ch2: got %b want 111", bus.rd_data); end
        do_write(14'd100, 3'b000, 3'b000);
        do_read(14'd100);
        total++; if (bus.rd_data !== 3'b111) begin bad++; $display("FAIL wm_none: got %b want 111", bus.rd_data); end
    endtask

    task automatic test_read_first();
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 14'd7;
        bus.wr_data  = 3'b000;
        bus.wr_mask  = 3'b111;
        bus.rd_en    = 1'b1;
        bus.rd_addr  = 14'd7;
        tick();
        bus.wr_valid = 1'b0;
        bus.rd_en    = 1'b0;
        total++; if (bus.rd_data !== 3'b111) begin bad++; $display("FAIL rf_same_cycle: got %b want 111", bus.rd_data); end
        do_read(14'd7);
        total++; if (bus.rd_data !== 3'b000) begin bad++; $display("FAIL rf_next: got %b want 000", bus.rd_data); end
    endtask

    task automatic test_out_of_range();
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL oor_ready: got %b want 1", bus.wr_ready); end
        do_write(14'd12300, 3'b010, 3'b111);
        do_read(14'd12300);
        total++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 3'b000) begin
            bad++;
            $display("FAIL oor_read: got valid=%b data=%b want valid=1 data=000", bus.rd_valid, bus.rd_data);
        end
        do_read(14'd12);
        total++; if (bus.rd_data !== 3'b111) begin bad++; $display("FAIL oor_alias: got %b want 111", bus.rd_data); end
    endtask

    task automatic test_fill();
        int cycles;
        int dones;
        int ready_bad;
        cycles    = 0;
        dones     = 0;
        ready_bad = 0;
        // Start the fill together with a write that the fill must overwrite.
        bus.clr_color = 3'b100;
        bus.clr_start = 1'b1;
        bus.wr_valid  = 1'b1;
        bus.wr_addr   = 14'd20;
        bus.wr_data   = 3'b011;
        bus.wr_mask   = 3'b111;
        tick();
        bus.clr_start = 1'b0;
        bus.wr_valid  = 1'b0;
        while (bus.clr_busy === 1'b1 && cycles < 20000) begin
            cycles++;
            // clr_start in FILL (cycle 100) and in DONE must be ignored.
            if (bus.clr_done === 1'b1) begin
                dones++;
                bus.clr_start = 1'b1;
                bus.clr_color = 3'b011;
            end else if (cycles == 100) begin
                bus.clr_start = 1'b1;
                bus.clr_color = 3'b011;
            end else begin
                bus.clr_start = 1'b0;
            end
            if (bus.wr_ready !== 1'b0) ready_bad++;
            bus.rd_en   = (cycles <= 3);
            bus.rd_addr = 14'd12287;
            tick();
        end
        bus.clr_start = 1'b0;
        bus.rd_en     = 1'b0;
        total++; if (cycles != 12289) begin bad++; $display("FAIL fill_busy_cycles: got %0d want 12289", cycles); end
        total++; if (dones != 1) begin bad++; $display("FAIL fill_done_pulses: got %0d want 1", dones); end
        total++; if (ready_bad != 0) begin bad++; $display("FAIL fill_ready_low: got %0d high cycles want 0", ready_bad); end
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_after: got %b want 1", bus.wr_ready); end
        total++; if (bus.clr_done !== 1'b0) begin bad++; $display("FAIL fill_done_after: got %b want 0", bus.clr_done); end
        for (int a = 0; a < DEPTH; a++) model[a] = 3'b100;
        for (int a = 0; a < DEPTH; a++) do_read(14'(a));
        total++; if (bus.rd_data !== 3'b100) begin bad++; $display("FAIL fill_last: got %b want 100", bus.rd_data); end
    endtask

    task automatic test_abort();
        int         not_busy;
        int         done_seen;
        logic [13:0] a;
        logic [2:0]  e;
        not_busy  = 0;
        done_seen = 0;
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL ab_ready: got %b want 1", bus.wr_ready); end
        bus.clr_color = 3'b010;
        bus.clr_start = 1'b1;
        bus.wr_valid  = 1'b1;
        bus.wr_addr   = 14'd60;
        bus.wr_data   = 3'b001;
        bus.wr_mask   = 3'b111;
        tick();
        bus.clr_start = 1'b0;
        bus.wr_valid  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.clr_busy !== 1'b1 || bus.clr_done !== 1'b0) not_busy++;
            tick();
        end
        total++; if (not_busy != 0) begin bad++; $display("FAIL ab_busy: got %0d bad cycles want 0", not_busy); end
        reset = 1'b1;
        #1;
        total++;
        if (bus.clr_busy !== 1'b0 || bus.wr_ready !== 1'b0 || bus.clr_done !== 1'b0) begin
            bad++;
            $display("FAIL ab_reset_out: got busy=%b ready=%b done=%b want 0 0 0", bus.clr_busy, bus.wr_ready, bus.clr_done);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.clr_done !== 1'b0) done_seen++;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        if (bus.clr_done !== 1'b0) done_seen++;
        total++; if (done_seen != 0) begin bad++; $display("FAIL ab_no_done: got %0d pulses want 0", done_seen); end
        for (int i = 0; i < 50; i++) model[i] = 3'b010;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       begin a = 14'd0;     e = 3'b010; end
                1:       begin a = 14'd49;    e = 3'b010; end
                2:       begin a = 14'd50;    e = 3'b100; end
                3:       begin a = 14'd60;    e = 3'b001; end
                default: begin a = 14'd12287; e = 3'b100; end
            endcase
            do_read(a);
            total++;
            if (bus.rd_data !== e) begin
                bad++;
                $display("FAIL ab_read[%0d]: got %b want %b", a, bus.rd_data, e);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < DEPTH; a++) model[a] = 3'b111;
        test_reset();
        test_powerup();
        test_write_mask();
        test_read_first();
        test_out_of_range();
        test_fill();
        test_abort();
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rd_missing: got %0d reads without rd_valid want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
